// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the CPE-CPU core.
// Handshakes with instruction/data memory. Traps on an illegal opcode or a memory timeout.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i_h,
  input  logic [6:0]       opcode_w_i,
  input  logic             reg_write_w_i_h,
  input  logic             mem_rd_w_i_h,
  input  logic             mem_wr_w_i_h,
  input  logic             branch_w_i_h,
  input  logic             imem_ack_w_i_h,
  input  logic             dmem_ack_w_i_h,
  output logic             imem_req_w_o_h,
  output logic             dmem_rd_w_o_h,
  output logic             dmem_wr_w_o_h,
  output logic             ir_en_w_o_h,
  output logic             pc_en_w_o_h,
  output logic             reg_wr_en_w_o_h,
  output logic             trap_w_o_h,
  output logic [2:0]       state_w_o,
  output logic [CNT_W-1:0] instret_w_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  instret;
  logic              legal, expired, retire;
  logic              imem_req, dmem_rd, dmem_wr, ir_en, reg_wr_en;

  // Branches need no flag-specific handling. They fall out of EXECUTE when no other flag is set.
  logic unused_branch;
  assign unused_branch = branch_w_i_h;

  always_comb begin
    case (opcode_w_i)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
  end

  assign expired = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_rd   = 1'b0;
    dmem_wr   = 1'b0;
    ir_en     = 1'b0;
    reg_wr_en = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack_w_i_h) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE:  state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (mem_rd_w_i_h || mem_wr_w_i_h) begin
          state_d = S_MEM;
        end else if (reg_write_w_i_h) begin
          state_d = S_WB;
        end else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // A read wins over a write, so the two data requests never overlap.
        dmem_rd = mem_rd_w_i_h;
        dmem_wr = mem_wr_w_i_h & ~mem_rd_w_i_h;
        if (dmem_ack_w_i_h) begin
          if (mem_rd_w_i_h) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (expired) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    if (rst_i_h) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        wait_cnt <= '0;
      end else if (state == S_FETCH || state == S_MEM) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (retire) begin
        instret <= instret + 1'b1;
      end
    end
  end

  // Requests and pulses are forced low for the whole reset cycle, even mid-handshake.
  assign imem_req_w_o_h  = imem_req  & ~rst_i_h;
  assign dmem_rd_w_o_h   = dmem_rd   & ~rst_i_h;
  assign dmem_wr_w_o_h   = dmem_wr   & ~rst_i_h;
  assign ir_en_w_o_h     = ir_en     & ~rst_i_h;
  assign pc_en_w_o_h     = retire    & ~rst_i_h;
  assign reg_wr_en_w_o_h = reg_wr_en & ~rst_i_h;
  assign trap_w_o_h      = (state == S_TRAP);
  assign state_w_o       = state;
  assign instret_w_o     = instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer.
// Stimulus queues the hand-computed expected outputs for each cycle, and a negedge monitor checks them.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opc;
  logic        rw, mr, mw, br, iack, dack;
  logic        imem_req, dmem_rd, dmem_wr, ir_en, pc_en, reg_wr_en, trap;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_i_h         (rst),
    .opcode_w_i      (opc),
    .reg_write_w_i_h (rw),
    .mem_rd_w_i_h    (mr),
    .mem_wr_w_i_h    (mw),
    .branch_w_i_h    (br),
    .imem_ack_w_i_h  (iack),
    .dmem_ack_w_i_h  (dack),
    .imem_req_w_o_h  (imem_req),
    .dmem_rd_w_o_h   (dmem_rd),
    .dmem_wr_w_o_h   (dmem_wr),
    .ir_en_w_o_h     (ir_en),
    .pc_en_w_o_h     (pc_en),
    .reg_wr_en_w_o_h (reg_wr_en),
    .trap_w_o_h      (trap),
    .state_w_o       (state),
    .instret_w_o     (instret)
  );

  // o bits: {imem_req, dmem_rd, dmem_wr, ir_en, pc_en, reg_wr_en, trap}
  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  o;
    logic [31:0] ir;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e, mon_a;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e    = sb_q.pop_front();
      mon_a.st = state;
      mon_a.o  = {imem_req, dmem_rd, dmem_wr, ir_en, pc_en, reg_wr_en, trap};
      mon_a.ir = instret;
      total++;
      if (mon_a !== mon_e) begin
        bad++;
        $display("FAIL cycle%0d: got st=%0d o=%b instret=%0d, want st=%0d o=%b instret=%0d",
                 cyc_n, mon_a.st, mon_a.o, mon_a.ir, mon_e.st, mon_e.o, mon_e.ir);
      end
    end
  end

  task automatic cyc(input logic [2:0] st, input logic [6:0] o, input int unsigned ir);
    exp_t e;
    e.st = st;
    e.o  = o;
    e.ir = ir;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [6:0] op, input logic w, input logic rd, input logic wr,
                         input logic b);
    opc = op;
    rw  = w;
    mr  = rd;
    mw  = wr;
    br  = b;
  endtask

  initial begin
    rst = 1'b1; iack = 1'b0; dack = 1'b0;
    set_dec(7'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cyc(3'd0, 7'b0000000, 0);                    // reset held: FETCH, everything low

    // ADDI, zero-wait: 0,1,2,4 with pc_en/reg_wr_en only in WB
    rst = 1'b0; iack = 1'b1; dack = 1'b1;
    set_dec(7'b0010011, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(3'd0, 7'b1001000, 0);
    cyc(3'd1, 7'b0000000, 0);
    cyc(3'd2, 7'b0000000, 0);
    cyc(3'd4, 7'b0000110, 0);

    // Load, dmem ack after two wait cycles: dmem_rd high for 3 cycles
    set_dec(7'b0000011, 1'b1, 1'b1, 1'b0, 1'b0);
    dack = 1'b0;
    cyc(3'd0, 7'b1001000, 1);
    cyc(3'd1, 7'b0000000, 1);
    cyc(3'd2, 7'b0000000, 1);
    cyc(3'd3, 7'b0100000, 1);
    cyc(3'd3, 7'b0100000, 1);
    dack = 1'b1;
    cyc(3'd3, 7'b0100000, 1);
    cyc(3'd4, 7'b0000110, 1);

    // Store retires in MEM without reg_wr_en, then BEQ retires in EXECUTE
    set_dec(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(3'd0, 7'b1001000, 2);
    cyc(3'd1, 7'b0000000, 2);
    cyc(3'd2, 7'b0000000, 2);
    cyc(3'd3, 7'b0010100, 2);
    set_dec(7'b1100011, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(3'd0, 7'b1001000, 3);
    cyc(3'd1, 7'b0000000, 3);
    cyc(3'd2, 7'b0000100, 3);

    // Reset asserted while a store waits in MEM
    set_dec(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    dack = 1'b0;
    cyc(3'd0, 7'b1001000, 4);
    cyc(3'd1, 7'b0000000, 4);
    cyc(3'd2, 7'b0000000, 4);
    cyc(3'd3, 7'b0010000, 4);
    rst = 1'b1;
    cyc(3'd3, 7'b0000000, 4);
    rst = 1'b0; iack = 1'b0;
    cyc(3'd0, 7'b1000000, 0);

    // Illegal opcode: DECODE->TRAP, sticky with acks ignored, cleared only by reset
    set_dec(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    iack = 1'b1; dack = 1'b1;
    cyc(3'd0, 7'b1001000, 0);
    cyc(3'd1, 7'b0000000, 0);
    for (int i = 0; i < 20; i++) cyc(3'd5, 7'b0000001, 0);
    rst = 1'b1;
    cyc(3'd5, 7'b0000001, 0);
    rst = 1'b0; iack = 1'b0;

    // Fetch timeout with TIMEOUT=4: four FETCH cycles, TRAP on the fifth
    for (int i = 0; i < 4; i++) cyc(3'd0, 7'b1000000, 0);
    cyc(3'd5, 7'b0000001, 0);
    cyc(3'd5, 7'b0000001, 0);
    rst = 1'b1;
    cyc(3'd5, 7'b0000001, 0);

    // Ack on the last allowed FETCH cycle wins over the timeout
    rst = 1'b0; iack = 1'b0;
    for (int i = 0; i < 3; i++) cyc(3'd0, 7'b1000000, 0);
    iack = 1'b1;
    set_dec(7'b0110111, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(3'd0, 7'b1001000, 0);
    iack = 1'b0;
    cyc(3'd1, 7'b0000000, 0);
    cyc(3'd2, 7'b0000000, 0);
    cyc(3'd4, 7'b0000110, 0);
    cyc(3'd0, 7'b1000000, 1);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the end of the bench");
    $fatal(1, "watchdog");
  end

endmodule
